// File: rtl/efuse_op_sched.sv
// efuse_op_sched
// Schedules eFuse read/program operations toward an external pulse generator.
// Two request sources share the pulse generator:
//   - an autoload sequencer that reads addresses 0..al_last after al_start
//   - a software request/acknowledge port for single read or program ops
// Each operation runs SETUP -> REFRESH -> WAIT -> CAPTURE -> CLEAR -> GAP.
// The CLEAR refresh, issued with both operation selects low, wipes the pulse
// generator's address history so that a repeated address still pulses.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   al_start, al_last   autoload start pulse and last address (inclusive)
//   al_busy             autoload sequence in progress
//   al_dvld, al_daddr   one-cycle strobe and address of the autoload word on rd_data
//   sw_req/sw_wr/sw_addr software request (held until sw_ack), op type, address
//   sw_ack              one-cycle strobe, request accepted
//   sw_done, sw_err     one-cycle completion strobe, error (timeout) flag
//   rd_data             last captured read word (autoload or software)
//   efuse_dout          macro read data, valid when efuse_aen_done is high
//   efuse_pgmen/rden    operation select toward the pulse generator
//   efuse_addr          address toward the pulse generator
//   efuse_refresh       one-cycle refresh pulse toward the pulse generator
//   efuse_aen_done      sticky done flag from the pulse generator
module efuse_op_sched #(
  parameter int TMO_CYC = 4095,
  parameter int GAP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       al_start,
  input  logic [7:0] al_last,
  output logic       al_busy,
  output logic       al_dvld,
  output logic [7:0] al_daddr,
  input  logic       sw_req,
  input  logic       sw_wr,
  input  logic [7:0] sw_addr,
  output logic       sw_ack,
  output logic       sw_done,
  output logic       sw_err,
  output logic [7:0] rd_data,
  input  logic [7:0] efuse_dout,
  output logic       efuse_pgmen,
  output logic       efuse_rden,
  output logic [7:0] efuse_addr,
  output logic       efuse_refresh,
  input  logic       efuse_aen_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    REFRESH = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    CLEAR   = 3'd5,
    GAP     = 3'd6
  } state_t;

  localparam int               GAP_W     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [12:0]      TMO_LIM   = 13'(TMO_CYC);
  // The done flag is sticky and may still be high from the previous
  // operation right after REFRESH, so it is not trusted this early in WAIT.
  localparam logic [11:0]      GUARD_CYC = 12'd2;

  state_t           state;
  state_t           nxt;
  logic [11:0]      wait_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       op_addr;
  logic             op_wr;
  logic             op_err;
  logic [7:0]       al_last_q;
  logic             al_pend;

  logic             start_al;
  logic             accept_sw;
  logic             timeout;
  logic             finish;
  logic             past_guard;
  logic             tmo_hit;
  logic             op_active;

  assign past_guard = (wait_cnt >= GUARD_CYC);
  // wait_cnt counts WAIT cycles already spent, so +1 is the current cycle.
  assign tmo_hit    = (({1'b0, wait_cnt} + 13'd1) >= TMO_LIM);
  assign op_active  = (state == SETUP) || (state == REFRESH) ||
                      (state == WAIT)  || (state == CAPTURE);

  // Next-state logic. A pending autoload always beats a software request.
  // Completion of a word either chains straight into the next autoload
  // address or returns to IDLE.
  always_comb begin
    nxt       = state;
    start_al  = 1'b0;
    accept_sw = 1'b0;
    timeout   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (al_start || al_pend) begin
          start_al = 1'b1;
          nxt      = SETUP;
        end else if (sw_req && !al_busy) begin
          accept_sw = 1'b1;
          nxt       = SETUP;
        end
      end
      SETUP:   nxt = REFRESH;
      REFRESH: nxt = WAIT;
      WAIT: begin
        if (past_guard && efuse_aen_done) begin
          nxt = CAPTURE;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          nxt     = CLEAR;
        end
      end
      CAPTURE: nxt = CLEAR;
      CLEAR: begin
        if (GAP_CYC == 0) begin
          finish = 1'b1;
        end else begin
          nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          finish = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
    if (finish) begin
      if (al_busy && (op_addr != al_last_q)) begin
        nxt = SETUP;
      end else begin
        nxt = IDLE;
      end
    end
  end

  // Pulse generator drive is decoded from the state so that everything
  // drops to zero the moment reset forces the state back to IDLE.
  always_comb begin
    efuse_pgmen   = 1'b0;
    efuse_rden    = 1'b0;
    efuse_addr    = 8'h00;
    efuse_refresh = 1'b0;
    if (op_active) begin
      efuse_pgmen = op_wr;
      efuse_rden  = !op_wr;
      efuse_addr  = op_addr;
    end
    if ((state == REFRESH) || (state == CLEAR)) begin
      efuse_refresh = 1'b1;
    end
  end

  // State register and datapath. Strobes default low every cycle; the
  // completion strobes are raised on the edge that leaves the last GAP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 12'd0;
      gap_cnt   <= '0;
      op_addr   <= 8'h00;
      op_wr     <= 1'b0;
      op_err    <= 1'b0;
      al_last_q <= 8'h00;
      al_pend   <= 1'b0;
      al_busy   <= 1'b0;
      al_dvld   <= 1'b0;
      al_daddr  <= 8'h00;
      sw_ack    <= 1'b0;
      sw_done   <= 1'b0;
      sw_err    <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      state   <= nxt;
      sw_ack  <= accept_sw;
      sw_done <= 1'b0;
      sw_err  <= 1'b0;
      al_dvld <= 1'b0;

      if (start_al) begin
        al_busy   <= 1'b1;
        al_pend   <= 1'b0;
        al_last_q <= al_last;
        op_addr   <= 8'h00;
        op_wr     <= 1'b0;
      end else if (al_start && !al_busy && (state != IDLE)) begin
        // Arrived while a software op owns the pulse generator; served next.
        al_pend <= 1'b1;
      end

      if (accept_sw) begin
        op_addr <= sw_addr;
        op_wr   <= sw_wr;
      end

      if (state == SETUP) begin
        op_err <= 1'b0;
      end

      if (state == REFRESH) begin
        wait_cnt <= 12'd0;
      end else if ((state == WAIT) && (wait_cnt != 12'hFFF)) begin
        wait_cnt <= wait_cnt + 12'd1;
      end

      if (timeout) begin
        op_err <= 1'b1;
      end

      if ((state == CAPTURE) && !op_wr) begin
        rd_data <= efuse_dout;
      end

      if (state == CLEAR) begin
        gap_cnt <= '0;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end

      if (finish) begin
        if (al_busy) begin
          al_dvld  <= 1'b1;
          al_daddr <= op_addr;
          if (op_addr == al_last_q) begin
            al_busy <= 1'b0;
          end else begin
            op_addr <= op_addr + 8'd1;
          end
        end else begin
          sw_done <= 1'b1;
          sw_err  <= op_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_efuse_op_sched.sv
// tb_efuse_op_sched
// Self-checking bench for efuse_op_sched. A small pulse generator model
// raises the sticky done flag a chosen number of cycles after each operation
// refresh and returns data from a randomly filled fuse array. Operations are
// applied from a table of vectors with hand-derived latencies, then from a
// randomized loop checked against a timing/data model of the scheduler.
module tb_efuse_op_sched;

  localparam int TMO = 20;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       al_start;
  logic [7:0] al_last;
  logic       al_busy;
  logic       al_dvld;
  logic [7:0] al_daddr;
  logic       sw_req;
  logic       sw_wr;
  logic [7:0] sw_addr;
  logic       sw_ack;
  logic       sw_done;
  logic       sw_err;
  logic [7:0] rd_data;
  logic [7:0] efuse_dout;
  logic       efuse_pgmen;
  logic       efuse_rden;
  logic [7:0] efuse_addr;
  logic       efuse_refresh;
  logic       efuse_aen_done;

  always #5 clk = ~clk;

  efuse_op_sched #(.TMO_CYC(TMO), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .al_start(al_start), .al_last(al_last), .al_busy(al_busy),
    .al_dvld(al_dvld), .al_daddr(al_daddr),
    .sw_req(sw_req), .sw_wr(sw_wr), .sw_addr(sw_addr),
    .sw_ack(sw_ack), .sw_done(sw_done), .sw_err(sw_err),
    .rd_data(rd_data), .efuse_dout(efuse_dout),
    .efuse_pgmen(efuse_pgmen), .efuse_rden(efuse_rden),
    .efuse_addr(efuse_addr), .efuse_refresh(efuse_refresh),
    .efuse_aen_done(efuse_aen_done)
  );

  // Pulse generator model: done is visible pg_delay cycles after the
  // operation refresh (0 = never), data comes from the fuse array.
  logic [7:0] fuse_mem [256];
  int         pg_delay = 10;
  int         pg_cnt;
  logic       pg_done;
  logic       force_done = 1'b0;

  assign efuse_aen_done = pg_done | force_done;
  assign efuse_dout     = fuse_mem[efuse_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg_cnt  <= 0;
      pg_done <= 1'b0;
    end else if (efuse_refresh && (efuse_pgmen || efuse_rden)) begin
      pg_done <= (pg_delay == 1);
      pg_cnt  <= (pg_delay > 1) ? pg_delay - 1 : 0;
    end else if (pg_cnt == 1) begin
      pg_done <= 1'b1;
      pg_cnt  <= 0;
    end else if (pg_cnt > 1) begin
      pg_cnt <= pg_cnt - 1;
    end
  end

  // Protocol invariants watched over the whole run.
  int   both_cnt    = 0;
  int   dbl_ref_cnt = 0;
  logic prev_ref    = 1'b0;

  always @(negedge clk) begin
    if (efuse_pgmen && efuse_rden) both_cnt <= both_cnt + 1;
    if (efuse_refresh && prev_ref) dbl_ref_cnt <= dbl_ref_cnt + 1;
    prev_ref <= efuse_refresh;
  end

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_rd = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Done becomes usable at max(d, 3) cycles after the refresh (two guard
  // cycles of WAIT are ignored); then CAPTURE, CLEAR and GAP precede the
  // strobe. Past the timeout budget the op aborts via CLEAR and GAP.
  function automatic int expTiming(input int d, output bit err);
    int usable;
    usable = (d < 3) ? 3 : d;
    if (d != 0 && usable <= TMO) begin
      err = 1'b0;
      return usable + 3 + GAP;
    end
    err = 1'b1;
    return TMO + 2 + GAP;
  endfunction

  // One software op: request, wait for ack, watch the refresh and the CLEAR
  // refresh, and report cycles from the op refresh to sw_done.
  task automatic applyStimulus(input bit wr, input logic [7:0] addr, input int d,
                               output int lat, output bit err, output logic [7:0] rd,
                               output int clr_cnt, output bit sel_ok);
    int ref_k;
    bit got;
    lat     = -1;
    err     = 1'b0;
    rd      = 8'h00;
    clr_cnt = 0;
    sel_ok  = 1'b0;
    pg_delay = d;
    sw_wr    = wr;
    sw_addr  = addr;
    sw_req   = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (sw_ack) got = 1'b1;
    end
    sw_req = 1'b0;
    if (!got) begin
      checkOutput("ack_wait_expired", 0, 1);
      return;
    end
    ref_k = -1;
    got   = 1'b0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("ack_one_cycle", sw_ack, 0);
      if (efuse_refresh && (efuse_pgmen || efuse_rden)) begin
        ref_k  = k;
        sel_ok = (efuse_pgmen == wr) && (efuse_rden == !wr) && (efuse_addr == addr);
      end
      if (efuse_refresh && !efuse_pgmen && !efuse_rden) clr_cnt++;
      if (sw_done) begin
        got = 1'b1;
        lat = k - ref_k;
        err = sw_err;
        rd  = rd_data;
      end
    end
    if (!got) checkOutput("done_wait_expired", 0, 1);
  endtask

  task automatic runOp(input string tag, input bit wr, input logic [7:0] addr,
                       input int d, input bit exp_err, input int exp_lat);
    int         lat;
    int         clr;
    bit         err;
    bit         sel;
    logic [7:0] rd;
    applyStimulus(wr, addr, d, lat, err, rd, clr, sel);
    if (!wr && !exp_err) exp_rd = fuse_mem[addr];
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_err"}, err, exp_err);
    checkOutput({tag, "_rd_data"}, rd, exp_rd);
    checkOutput({tag, "_clear_refresh"}, clr, 1);
    checkOutput({tag, "_op_select"}, sel, 1);
  endtask

  // Autoload 0..last with a software read of 0x5A requested in the same
  // cycle; the software op must wait until al_busy falls.
  task automatic runAutoload(input logic [7:0] last);
    int n_dvld;
    int dvld_k;
    int ack_k;
    bit fin;
    pg_delay = 10;
    al_last  = last;
    al_start = 1'b1;
    sw_wr    = 1'b0;
    sw_addr  = 8'h5A;
    sw_req   = 1'b1;
    @(negedge clk);
    al_start = 1'b0;
    checkOutput("al_busy_set", al_busy, 1);
    checkOutput("al_sw_ack_blocked", sw_ack, 0);
    n_dvld = 0;
    dvld_k = -1;
    ack_k  = -1;
    fin    = 1'b0;
    for (int k = 1; k <= 400 && !fin; k++) begin
      @(negedge clk);
      if (al_dvld) begin
        checkOutput($sformatf("al_daddr_%0d", n_dvld), al_daddr, n_dvld);
        checkOutput($sformatf("al_data_%0d", n_dvld), rd_data, fuse_mem[n_dvld]);
        checkOutput($sformatf("al_busy_%0d", n_dvld), al_busy, (n_dvld == int'(last)) ? 0 : 1);
        n_dvld++;
        dvld_k = k;
      end
      if (sw_ack) begin
        ack_k  = k;
        sw_req = 1'b0;
      end
      if (sw_done) begin
        fin = 1'b1;
        checkOutput("al_sw_err", sw_err, 0);
        checkOutput("al_sw_rd_data", rd_data, fuse_mem[8'h5A]);
      end
    end
    sw_req = 1'b0;
    checkOutput("al_dvld_count", n_dvld, int'(last) + 1);
    checkOutput("al_sw_ack_after_busy", ack_k, dvld_k + 1);
    checkOutput("al_sw_done_seen", fin, 1);
    exp_rd = fuse_mem[8'h5A];
  endtask

  // Reset asserted while WAITing for a done that never comes.
  task automatic resetMidOp();
    bit got;
    int done_cnt;
    pg_delay = 0;
    sw_wr    = 1'b0;
    sw_addr  = 8'h3C;
    sw_req   = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (sw_ack) got = 1'b1;
    end
    sw_req = 1'b0;
    checkOutput("rst_ack_seen", got, 1);
    repeat (4) @(negedge clk);
    checkOutput("rst_in_wait_rden", efuse_rden, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_outputs",
                {al_busy, al_dvld, al_daddr, sw_ack, sw_done, sw_err, rd_data,
                 efuse_pgmen, efuse_rden, efuse_addr, efuse_refresh}, 32'h0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (sw_done) done_cnt++;
    end
    rst_n = 1'b1;
    exp_rd = 8'h00;
    repeat (5) begin
      @(negedge clk);
      if (sw_done) done_cnt++;
    end
    checkOutput("rst_no_done_strobe", done_cnt, 0);
    checkOutput("rst_rd_data_cleared", rd_data, 8'h00);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    int         d;
    bit         exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int  lat;
    bit  e;
    bit  wr;
    int  d;
    logic [7:0] a;

    vecs[0] = '{1'b0, 8'h21, 10, 1'b0, 15};
    vecs[1] = '{1'b1, 8'h10, 10, 1'b0, 15};
    vecs[2] = '{1'b1, 8'h10, 10, 1'b0, 15};
    vecs[3] = '{1'b0, 8'h33,  1, 1'b0,  8};
    vecs[4] = '{1'b0, 8'h44,  4, 1'b0,  9};
    vecs[5] = '{1'b0, 8'h55, 20, 1'b0, 25};
    vecs[6] = '{1'b0, 8'h66, 21, 1'b1, 24};
    vecs[7] = '{1'b0, 8'h77,  0, 1'b1, 24};

    for (int i = 0; i < 256; i++) fuse_mem[i] = 8'($urandom_range(1, 255));

    rst_n    = 1'b0;
    al_start = 1'b0;
    al_last  = 8'h00;
    sw_req   = 1'b0;
    sw_wr    = 1'b0;
    sw_addr  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {al_busy, al_dvld, al_daddr, sw_ack, sw_done, sw_err, rd_data,
                 efuse_pgmen, efuse_rden, efuse_addr, efuse_refresh}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] autoload of addresses 0..3 with a blocked software read");
    runAutoload(8'd3);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].d,
            vecs[i].exp_err, vecs[i].exp_lat);
    end

    $display("[TB] done flag stuck high through the guard cycles");
    force_done = 1'b1;
    runOp("stuck_done", 1'b0, 8'h2B, 0, 1'b0, 8);
    force_done = 1'b0;

    $display("[TB] reset while waiting");
    resetMidOp();
    runOp("post_reset", 1'b0, 8'h3C, 6, 1'b0, 11);

    $display("[TB] randomized operations");
    for (int i = 0; i < 25; i++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = 8'($urandom_range(0, 255));
      d   = $urandom_range(0, TMO + 4);
      lat = expTiming(d, e);
      runOp($sformatf("rnd%0d", i), wr, a, d, e, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    checkOutput("pgmen_rden_overlap", both_cnt, 0);
    checkOutput("refresh_back_to_back", dbl_ref_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no end, expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/efuse_op_sched.md
EFUSE_OP_SCHED -- requirements
Module: efuse_op_sched

Interface
REQ-001 Parameter TMO_CYC, default 4095, max cycles in WAIT before the operation is aborted with error.
REQ-002 Parameter GAP_CYC, default 2, idle cycles inserted in GAP after each address-clear pulse.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 al_start  input  1  pulse; start autoload of addresses 0..al_last.
REQ-006 al_last  input  8  last autoload address, inclusive.
REQ-007 al_busy  output  1  autoload sequence in progress.
REQ-008 al_dvld  output  1  one-cycle strobe; al_daddr/al_data valid.
REQ-009 al_daddr  output  8  address of autoload word just read.
REQ-010 sw_req  input  1  software op request; held until sw_ack.
REQ-011 sw_wr  input  1  1 = program, 0 = read; sampled with sw_req.
REQ-012 sw_addr  input  8  software op address; sampled with sw_req.
REQ-013 sw_ack  output  1  one-cycle strobe; request accepted.
REQ-014 sw_done  output  1  one-cycle strobe; software op finished.
REQ-015 sw_err  output  1  valid with sw_done; 1 = timeout.
REQ-016 rd_data  output  8  last captured read word (autoload or software); al_data is the same bus.
REQ-017 efuse_dout  input  8  macro read data, valid when efuse_aen_done rises.
REQ-018 efuse_pgmen / efuse_rden  output  1 each  operation select to pulse generator.
REQ-019 efuse_addr  output  8  address to pulse generator.
REQ-020 efuse_refresh  output  1  one-cycle refresh pulse to pulse generator.
REQ-021 efuse_aen_done  input  1  sticky done from pulse generator.

Function
REQ-022 FSM states: IDLE, SETUP, REFRESH, WAIT, CAPTURE, CLEAR, GAP.
REQ-023 IDLE: autoload pending has priority over sw_req; sw_req is not acked while al_busy=1.
REQ-024 al_start in IDLE sets al_busy, loads addr counter to 0, goes to SETUP; al_start while al_busy is ignored.
REQ-025 sw_req in IDLE with al_busy=0: sw_ack pulses, sw_wr/sw_addr latched, go to SETUP.
REQ-026 SETUP (1 cycle): efuse_addr and exactly one of efuse_pgmen/efuse_rden driven; both held stable through CAPTURE.
REQ-027 REFRESH (1 cycle): efuse_refresh=1.
REQ-028 WAIT: efuse_aen_done ignored for the first 2 cycles after REFRESH; then its high level moves to CAPTURE.
REQ-029 WAIT cycle counter (12 bit, saturating) reaching TMO_CYC moves to CLEAR with error flag set.
REQ-030 CAPTURE (1 cycle): on read, rd_data <= efuse_dout; on program, rd_data unchanged.
REQ-031 CLEAR (1 cycle): efuse_pgmen=efuse_rden=0 and efuse_refresh=1, so the pulse generator's address history is cleared and a repeat of the same address still pulses.
REQ-032 GAP: GAP_CYC cycles with all efuse outputs 0, then completion actions and return.
REQ-033 Autoload completion per word: al_dvld pulses with al_daddr; if addr==al_last, al_busy clears and go IDLE, else addr+1 and go SETUP; 8-bit counter never wraps.
REQ-034 Autoload timeout: al_dvld still pulses (rd_data unchanged), sequence continues.
REQ-035 Software completion: sw_done pulses with sw_err, go IDLE.
REQ-036 efuse_pgmen and efuse_rden never both 1; efuse_refresh is never high two consecutive cycles.

Reset
REQ-037 rst_n low: FSM IDLE; all outputs 0, including rd_data, al_daddr, al_busy, efuse_addr.
REQ-038 Reset mid-operation aborts immediately with no completion strobe; first post-reset op starts from IDLE.

Verification
REQ-039 al_last=3, al_start, model done 10 cycles after each refresh -> 4 al_dvld strobes, addresses 0..3, rd_data matches efuse_dout each time, al_busy falls after the 4th.
REQ-040 sw_req (rd, addr 0x5A) asserted during autoload -> sw_ack only after al_busy falls; sw_done=1, sw_err=0.
REQ-041 Two back-to-back sw program ops to addr 0x10 -> each sequence shows a CLEAR refresh with pgmen=rden=0, both complete.
REQ-042 efuse_aen_done held 0, TMO_CYC=20 -> sw_done with sw_err=1 at 20 WAIT cycles, followed by CLEAR.
REQ-043 efuse_aen_done stuck 1 from the prior op -> not sampled in the 2 guard cycles after REFRESH.
REQ-044 rst_n asserted in WAIT -> all outputs 0 asynchronously, no sw_done; new sw_req after release completes normally.
